// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package imem_ctrl_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HALTING = 2'd2,
    HALTED  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Instruction buffer between the memory response port and the F stage.
// The head entry is read straight from the storage flops.
module fetch_fifo
  import imem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && (count_q != DEPTH_C);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: issues sequential word requests, tracks outstanding
// responses, discards stale ones after a redirect, and buffers instructions.
//   state   | meaning
//   BOOT    | first cycle after reset, no requests
//   RUN     | issuing sequential fetches
//   HALTING | no new requests, waiting for in-flight responses
//   HALTED  | idle until a redirect restarts fetch
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          MEM_AW   = 6,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 3,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_f,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              halt_req,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              halted,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int               CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_push, fifo_pop;
  fetch_entry_t     fifo_head, fifo_wdata;
  logic [CNT_W:0]   credit;
  logic             issue;
  logic [31:0]      target_pc;
  logic             unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  always_comb begin
    // Credit counts every live (non-discarded) response against FIFO space.
    credit    = {1'b0, inflight_q - drop_cnt_q} + {1'b0, fifo_count};
    mem_req   = (state_q == RUN) && !redirect && (inflight_q < MAX_OUT_C) && (credit < DEPTH_C);
    issue     = mem_req && mem_ready;
    target_pc = {redirect_pc[31:2], 2'b00};

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(mem_rvalid);
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_wdata = '{pc: resp_pc_q, instr: mem_rdata};

    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_cnt_d = inflight_q - CNT_W'(mem_rvalid);
    end else begin
      fifo_pop = !fifo_empty && !stall_f;
      if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
      if (mem_rvalid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end else begin
          fifo_push = 1'b1;
          resp_pc_d = resp_pc_q + PC_INC;
        end
      end
    end

    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_req && !redirect) state_d = HALTING;
      // Leave as soon as the last response lands so halted follows it directly.
      HALTING: if (!redirect && inflight_d == '0) state_d = HALTED;
      HALTED:  if (redirect) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata (fifo_wdata),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;
  assign halted      = (state_q == HALTED);
  assign mem_addr    = fetch_pc_q[MEM_AW+1:2];

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized bench for imem_fetch_ctrl against a queue-based fetch model.
module tb_imem_fetch_ctrl;

  localparam int MEM_AW  = 6;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall_f, redirect, halt_req;
  logic [31:0]       redirect_pc;
  logic              instr_valid, halted, mem_req;
  logic [31:0]       instr, instr_pc;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ready, mem_rvalid;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .MEM_AW   (MEM_AW),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .halted      (halted),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  typedef struct { logic [31:0] pc; bit stale; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [MEM_AW-1:0] addr; int due; } mreq_t;

  out_t        outst[$];
  ent_t        fq[$];
  mreq_t       mq[$];
  logic [31:0] ram [64];
  logic [31:0] m_pc;
  bit          m_boot, m_halting, m_halted;
  int          cyc, last_due, first_valid;
  int          lat_min, lat_max, p_stall, p_redir, p_ready;
  bit          halt_on, redir_force;
  logic [31:0] redir_target;
  int          n_checks, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_init();
    outst.delete(); fq.delete(); mq.delete();
    m_pc = 32'h0; m_boot = 1; m_halting = 0; m_halted = 0;
    cyc = 0; last_due = -1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(4, 0))
      0: return 32'h0000_0042;
      1: return 32'h0000_00FC;
      2: return 32'hFFFF_FFF8 | 32'($urandom_range(3, 0));
      3: return $urandom;
      default: return 32'($urandom_range(255, 0));
    endcase
  endfunction

  // One clock cycle: drive inputs at the falling edge, check, advance the model.
  task automatic step();
    bit   running, exp_req, issue, pop, rv;
    int   live, lat, due;
    out_t o;
    stall_f  = ($urandom_range(99, 0) < p_stall);
    halt_req = halt_on;
    mem_ready = ($urandom_range(99, 0) < p_ready);
    if (redir_force) begin
      redirect = 1; redirect_pc = redir_target; redir_force = 0;
    end else begin
      redirect = ($urandom_range(99, 0) < p_redir);
      redirect_pc = pick_target();
    end
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    mem_rvalid = rv;
    mem_rdata  = rv ? ram[mq[0].addr] : $urandom;
    #1;
    running = !m_boot && !m_halting && !m_halted;
    live = 0;
    foreach (outst[i]) if (!outst[i].stale) live++;
    exp_req = running && !redirect && (outst.size() < MAX_OUT) && (live + fq.size() < DEPTH);
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    chk("mem_addr", 32'(mem_addr), {26'b0, m_pc[7:2]});
    chk("instr_valid", 32'(instr_valid), 32'(fq.size() > 0));
    if (fq.size() > 0) begin
      chk("instr", instr, fq[0].data);
      chk("instr_pc", instr_pc, fq[0].pc);
    end
    chk("halted", 32'(halted), 32'(m_halted));
    if (instr_valid && first_valid < 0) first_valid = cyc;

    if (rv) void'(mq.pop_front());
    if (mem_req && mem_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      mq.push_back('{addr: mem_addr, due: due});
    end

    issue = exp_req && mem_ready;
    pop   = (fq.size() > 0) && !stall_f && !redirect;
    if (redirect) begin
      fq.delete();
      if (rv && outst.size() > 0) void'(outst.pop_front());
      foreach (outst[i]) outst[i].stale = 1;
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) void'(fq.pop_front());
      if (rv && outst.size() > 0) begin
        o = outst.pop_front();
        if (!o.stale) fq.push_back('{pc: o.pc, data: ram[o.pc[7:2]]});
      end
      if (issue) begin
        outst.push_back('{pc: m_pc, stale: 0});
        m_pc = m_pc + 32'd4;
      end
    end

    if (m_boot) m_boot = 0;
    else if (running) begin
      if (halt_req && !redirect) m_halting = 1;
    end else if (m_halting) begin
      if (!redirect && outst.size() == 0) begin m_halting = 0; m_halted = 1; end
    end else if (m_halted) begin
      if (redirect) m_halted = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_mode(input int lmin, input int lmax, input int ps, input int pr, input int py);
    lat_min = lmin; lat_max = lmax; p_stall = ps; p_redir = pr; p_ready = py;
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    model_init();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; first_valid = -1;
    halt_on = 0; redir_force = 0; redir_target = 0;
    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    reset = 0; stall_f = 0; redirect = 0; redirect_pc = 0; halt_req = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    model_init();
    #1;
    check_reset_outputs();
    release_reset();

    set_mode(1, 1, 0, 0, 100);
    for (int i = 0; i < 20; i++) step();
    chk("first_valid_cyc", 32'(first_valid), 32'd3);

    set_mode(1, 1, 100, 0, 100);
    for (int i = 0; i < 10; i++) step();
    set_mode(1, 1, 0, 0, 100);
    for (int i = 0; i < 10; i++) step();

    set_mode(3, 3, 0, 0, 100);
    for (int i = 0; i < 20 && outst.size() != 2; i++) step();
    redir_force = 1; redir_target = 32'h0000_0042;
    for (int i = 0; i < 15; i++) step();

    set_mode(2, 2, 0, 0, 100);
    halt_on = 1;
    for (int i = 0; i < 15; i++) step();
    halt_on = 0; redir_force = 1; redir_target = 32'h0;
    for (int i = 0; i < 10; i++) step();

    set_mode(1, 1, 0, 0, 100);
    redir_force = 1; redir_target = 32'h0000_00F8;
    for (int i = 0; i < 8; i++) step();

    set_mode(1, 4, 30, 5, 70);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) < 2) halt_on = !halt_on;
      step();
    end
    halt_on = 0;

    set_mode(1, 1, 0, 0, 100);
    for (int i = 0; i < 6; i++) step();
    #3 reset = 0;
    mem_rvalid = 0;
    #1;
    check_reset_outputs();
    release_reset();
    for (int i = 0; i < 20; i++) step();
    set_mode(1, 3, 20, 5, 80);
    for (int i = 0; i < 500; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch-side sequencer for the word-indexed instruction memory (64 x 32, combinational read).
- The memory is now wrapped behind a request/response port with variable latency.
- The block generates sequential fetch PCs, converts byte PCs to word indices, bounds outstanding requests, and buffers returned instructions in a small FIFO for the F stage.
- It handles stall, branch/jump redirect (flush plus discard of in-flight responses), and a halt/drain request from the hazard unit.

Parameters:
- MEM_AW, 6, word-index width of the instruction memory (64 words).
- DEPTH, 4, instruction FIFO depth (power of 2, >= 2).
- MAX_OUT, 3, maximum outstanding memory requests (<= DEPTH).
- RESET_PC, 32'h0000_0000, first fetch byte address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_f  in  1  F stage cannot accept an instruction this cycle.
- redirect  in  1  taken branch/jump; refetch from redirect_pc.
- redirect_pc  in  32  byte target; bits [1:0] ignored (forced 00).
- halt_req  in  1  level; stop issuing and drain.
- instr_valid  out  1  instr/instr_pc hold a valid fetched instruction.
- instr  out  32  instruction word.
- instr_pc  out  32  byte PC of instr.
- halted  out  1  high in HALTED state.
- mem_req  out  1  request valid.
- mem_addr  out  MEM_AW  word index = fetch_pc[MEM_AW+1:2].
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  response valid; responses return in order.
- mem_rdata  in  32  response data.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - state=BOOT, fetch_pc=RESET_PC, inflight=0, drop_cnt=0, FIFO empty.
  - Outputs: instr_valid=0, instr=0, instr_pc=0, halted=0, mem_req=0, mem_addr=RESET_PC[MEM_AW+1:2].
  - Reset mid-operation abandons everything. Responses arriving after reset release that belong to pre-reset requests are the memory wrapper's responsibility; the wrapper is reset on the same net.
- **FSM states:** BOOT, RUN, HALTING, HALTED.
  - BOOT -> RUN unconditionally, one cycle after reset release.
  - RUN -> HALTING when halt_req=1 and redirect=0.
  - HALTING -> HALTED when inflight=0.
  - HALTED -> RUN on redirect=1. halt_req must be low by then, otherwise the FSM re-enters HALTING next cycle.
  - redirect in HALTING is accepted: fetch_pc is updated, the FIFO is flushed, and the state stays HALTING.
- **Issue:**
  - mem_req = (state==RUN) & !redirect & (inflight < MAX_OUT) & ((inflight - drop_cnt) + fifo_count < DEPTH).
  - issue = mem_req & mem_ready. On issue, fetch_pc <= fetch_pc + 4, wrapping mod 2^32; mem_addr wraps mod 2^MEM_AW.
  - mem_addr and mem_req hold stable while mem_req=1 and mem_ready=0.
- **Response:**
  - inflight <= inflight + issue - mem_rvalid.
  - If mem_rvalid and drop_cnt>0, the data is discarded and drop_cnt decrements.
  - Otherwise the FIFO is written with {pc_tag, mem_rdata}. The pc_tag comes from a shadow queue of issued PCs; an equivalent implementation is a second counter, resp_pc, advanced per accepted response.
- **Redirect (priority over all same-cycle events):**
  - FIFO flushed; fetch_pc <= {redirect_pc[31:2],2'b00}.
  - drop_cnt <= inflight - mem_rvalid; a response arriving in the redirect cycle is discarded.
  - resp_pc <= redirect target. No issue occurs in the redirect cycle.
  - A consume in the same cycle is suppressed.
  - The next-cycle instr_valid is 0.
- **Output:**
  - FIFO head is registered. instr_valid = !fifo_empty.
  - Consume = instr_valid & !stall_f & !redirect, which pops the head.
  - A FIFO write on cycle N is visible at the head on N+1.
  - Simultaneous push and pop at fifo_count==DEPTH cannot occur, because credit prevents overflow.
  - Write plus pop when empty: the pushed entry appears on N+1.
- **Latency and throughput:**
  - With mem_ready=1 and a 1-cycle memory, the first request is issued in the cycle after BOOT.
  - instr_valid rises 2 cycles after the first issue.
  - Steady state is 1 instr/cycle with DEPTH>=MAX_OUT+1.
- **halted:** 1 only in HALTED. The FIFO contents remain consumable while HALTING/HALTED.

Decomposition:
- **Package imem_ctrl_pkg:**
  - State enum (BOOT, RUN, HALTING, HALTED) as 2-bit typedef.
  - Constants INSTR_W=32, PC_INC=4.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
- **Sub-module fetch_fifo:**
  - Synchronous FIFO of fetch_entry_t, parameter DEPTH.
  - Ports: push, pop, flush (flush dominates), count, head, empty.
  - Asynchronous active-low reset on the same reset net.

Test Plan:
- Reset release with mem_ready=1 and 1-cycle memory returning RAM[addr]: mem_addr sequence 0,1,2,…; instr_pc 0x0,0x4,0x8 on consecutive cycles; instr_valid first high 3 cycles after reset release.
- Hold stall_f=1 for 10 cycles: mem_req drops after the FIFO and inflight total 4; instr/instr_pc stay stable; on release, ordering continues with no gaps or duplicates.
- Memory latency 3 with 2 in flight, then redirect to 0x0000_0042: both in-flight responses discarded; next instr_pc=0x40, mem_addr=0x10; no stale instr ever has instr_valid=1.
- Redirect in the same cycle as mem_rvalid and a consume: response dropped, FIFO empty next cycle, drop_cnt = inflight-1.
- halt_req with 2 outstanding: no new mem_req; halted rises the cycle after the last rvalid; redirect to 0x0 returns to RUN and fetch resumes at word 0.
- fetch_pc=0xFC (word 63): next mem_addr wraps to 0 and instr_pc=0x100; assert reset mid-burst, then all outputs are at reset values within the same cycle.
